data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port word memory behind a valid/ready request channel and a
//   valid/ready response channel. It holds one request at a time: the request
//   is latched on acceptance, it waits LAT cycles, and then it is answered.
//   Writes are merged into storage by byte lane on the edge that enters RESP.
//   Reads capture the stored word on that same edge. Misaligned and
//   out-of-range addresses are answered with rsp_err = 1 and never touch
//   storage.
//
// Parameters
//   DEPTH  number of 32-bit words (power of two, 4..65536)
//   LAT    wait-state cycles between acceptance and response (0..15)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-low
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data, little-endian lanes
//   req_be     in   byte enables, bit n covers req_wdata[8n+7:8n]
//   rsp_valid  out  response available
//   rsp_ready  in   response accepted
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  misaligned or out-of-range request
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Request fields, latched on acceptance.
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            err_q;

  // Response fields.
  logic            rsp_err_q;
  logic            rd_ok_q;
  logic [31:0]     rd_word;

  logic            accept;
  logic            enter_resp;
  logic            req_err;
  logic            wr_en;

  // Fields of the request being completed. With LAT == 0, RESP is entered on
  // the acceptance edge itself, so the live inputs are used while in IDLE.
  logic            cur_we;
  logic            cur_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_be;

  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? rd_word : 32'h0;

  assign cur_we    = (state_q == IDLE) ? req_we               : we_q;
  assign cur_err   = (state_q == IDLE) ? req_err              : err_q;
  assign cur_idx   = (state_q == IDLE) ? req_addr[AW+1:2]     : idx_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata            : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be               : be_q;
  assign wr_en     = cur_we && !cur_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LAT == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rsp_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rsp_err_q <= cur_err;
        rd_ok_q   <= !cur_err && !cur_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      be_q    <= req_be;
      err_q   <= req_err;
    end
  end

  // One RAM per byte lane, so each lane has its own write enable. Storage has
  // no reset. The write is gated by reset so that a request abandoned by reset
  // leaves storage untouched.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem_q [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (reset && enter_resp) begin
        if (wr_en && cur_be[gi]) begin
          lane_mem_q[cur_idx] <= cur_wdata[8*gi +: 8];
        end
        rd_byte_q <= lane_mem_q[cur_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. It builds three instances with DEPTH = 256
// and LAT set to 1, 0 and 3, and drives them with a table of directed
// vectors, hand-written corner sequences and randomized traffic. The expected
// results come from a word-array model of storage.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_mem_responder #(
      .DEPTH(256),
      .LAT  (gi == 0 ? 1 : (gi == 1 ? 0 : 3))
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n[gi]),
      .req_valid(req_valid[gi]),
      .req_ready(req_ready[gi]),
      .req_we   (req_we[gi]),
      .req_addr (req_addr[gi]),
      .req_wdata(req_wdata[gi]),
      .req_be   (req_be[gi]),
      .rsp_valid(rsp_valid[gi]),
      .rsp_ready(rsp_ready[gi]),
      .rsp_rdata(rsp_rdata[gi]),
      .rsp_err  (rsp_err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Storage model: the first 16 words of each instance.
  logic [31:0] mm [3][16];

  function automatic int lat_of(input int k);
    if (k == 0) return 1;
    if (k == 1) return 0;
    return 3;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [17];

  // Every call starts and ends just after a falling edge, with the DUT idle.
  task automatic xact(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int stall,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    rsp_ready[k] = (stall == 0);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    // Hold the response back while a stray write to word 1 is presented. The
    // DUT must ignore that write.
    for (int s = 0; s < stall; s++) begin
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h4;
      req_wdata[k] = 32'hFFFF_FFFF;
      req_be[k]    = 4'hF;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata[k], rdata);
      chk("hold_rsp_err", 32'(rsp_err[k]), 32'(err));
      chk("busy_req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    chk("idle_req_ready", 32'(req_ready[k]), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    $display("xact dut=%0d we=%0d addr=%h wdata=%h be=%h stall=%0d -> rdata=%h err=%0d lat=%0d",
             k, we, addr, wdata, be, stall, rdata, err, lat);
  endtask

  // Model-checked transaction: the expected values come from the address rules
  // and the model array, not from the DUT.
  task automatic mxact(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic [31:0] rd;
    logic        er;
    int          lt;
    logic        ex_err;
    logic [31:0] ex_rd;
    int          w;
    ex_err = (addr % 4 != 0) || (addr >= 32'd1024);
    w      = int'(addr / 4);
    ex_rd  = 32'h0;
    if (!ex_err && !we) ex_rd = mm[k][w];
    xact(k, we, addr, wdata, be, stall, rd, er, lt);
    chk("model_rdata", rd, ex_rd);
    chk("model_err", 32'(er), 32'(ex_err));
    chk("model_latency", 32'(lt), 32'(1 + lat_of(k)));
    if (!ex_err && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mm[k][w][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [31:0] prior;
    logic [31:0] addr;
    int          sel;
    int          idx;

    tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0004, 32'h5555_5555, 4'hF, 0, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0, 32'h0,         1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 5, 32'h11BB_33DD, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0004, 32'h0,         4'hF, 0, 32'h5555_5555, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0402, 32'h0,         4'hF, 0, 32'h0,         1'b1};
    tbl[9]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 0, 32'h0BAD_F00D, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 0, 32'h11BB_33DD, 1'b0};
    tbl[13] = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF, 0, 32'h0,         1'b0};
    tbl[14] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0};
    tbl[15] = '{1'b0, 32'h8000_0000, 32'h0,         4'hF, 0, 32'h0,         1'b1};
    tbl[16] = '{1'b0, 32'h0000_0023, 32'h0,         4'hF, 0, 32'h0,         1'b1};

    for (int k = 0; k < 3; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
      rsp_ready[k] = 1'b1;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[k], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_reset_req_ready", 32'(req_ready[k]), 32'd1);

    // Directed table on the LAT=1 instance.
    for (int i = 0; i < 17; i++) begin
      xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].stall, rd, er, lt);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_latency", i), 32'(lt), 32'd2);
    end

    // Give the first 16 words of every instance known contents.
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 16; w++) begin
        mxact(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      end
    end

    // LAT=0: with request and response held valid/ready, accepts every 2 cycles.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h8;
    req_be[1]    = 4'hF;
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("sweep_req_ready", 32'(req_ready[1]), 32'(i % 2 == 0));
      chk("sweep_rsp_valid", 32'(rsp_valid[1]), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("sweep_rsp_rdata", rsp_rdata[1], mm[1][2]);
      $display("sweep cycle=%0d req_ready=%0d rsp_valid=%0d rdata=%h",
               i, req_ready[1], rsp_valid[1], rsp_rdata[1]);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;

    // LAT=3: reset during the second WAIT cycle abandons a write to 0x30.
    prior        = mm[2][12];
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h30;
    req_wdata[2] = ~prior;
    req_be[2]    = 4'hF;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("wait1_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("wait1_req_ready", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("rst_wait_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready[2]), 32'd0);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    end
    $display("reset-in-wait dut=2 addr=00000030 prior=%h", prior);
    mxact(2, 1'b0, 32'h30, 32'h0, 4'hF, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        sel  = $urandom_range(0, 9);
        idx  = $urandom_range(0, 15);
        addr = 32'(idx * 4);
        if (sel == 8) addr = addr | 32'($urandom_range(1, 3));
        if (sel == 9) addr = addr | (32'h1 << $urandom_range(10, 31));
        mxact(k, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
